// File: rtl/switch_write_feeder.sv
// Debounced switch sampler feeding the async FIFO write port.
// Ports: clk/rst, sw_in, full -> wdata, winc, pending, drop_cnt.
module switch_write_feeder #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  input  logic             full,
  output logic [WIDTH-1:0] wdata,
  output logic             winc,
  output logic             pending,
  output logic [7:0]       drop_cnt
);

  localparam logic IDLE = 1'b0;
  localparam logic PEND = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       drop_q, drop_d;
  logic             state_q, state_d;
  logic             ev;
  logic             wr;

  // Stable only once the synchronised value has sat unchanged
  // for the full window and differs from the last reported one.
  assign ev = (cnt_q == CNT_MAX) &&
              (s2_q == cand_q) &&
              (cand_q != stable_q);

  // Write request is combinational so full gates it in-cycle.
  assign wr = (state_q == PEND) && !full;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_comb begin
    stable_d = stable_q;
    wdata_d  = wdata_q;
    if (ev) begin
      stable_d = cand_q;
      wdata_d  = cand_q;
    end
  end

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (ev) state_d = PEND;
      end
      PEND: begin
        if (wr) begin
          // A new value arriving on the write edge queues behind it.
          state_d = ev ? PEND : IDLE;
        end else if (ev && drop_q != 8'hFF) begin
          // Unwritten value overwritten by a newer one.
          drop_d = drop_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      drop_q   <= '0;
      state_q  <= IDLE;
    end else begin
      s1_q     <= sw_in;
      s2_q     <= s1_q;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      state_q  <= state_d;
    end
  end

  assign wdata    = wdata_q;
  assign winc     = wr;
  assign pending  = (state_q == PEND);
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_switch_write_feeder.sv
// Directed bench for switch_write_feeder.
// Logs every FIFO write and checks against hand-derived values.
module tb_switch_write_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw_in = 8'h00;
  logic       full = 1'b0;
  logic [7:0] wdata;
  logic       winc;
  logic       pending;
  logic [7:0] drop_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] wq[$];

  switch_write_feeder #(
    .WIDTH(8),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_in(sw_in),
    .full(full),
    .wdata(wdata),
    .winc(winc),
    .pending(pending),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && winc) wq.push_back(wdata);

  task automatic check(string tag,
                       logic [31:0] obs,
                       logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wq.delete();
  endtask

  initial begin
    // Reset values while rst held
    tick();
    check("rst_winc", 32'(winc), 0);
    check("rst_pend", 32'(pending), 0);
    check("rst_wdata", 32'(wdata), 0);
    check("rst_drop", 32'(drop_cnt), 0);

    // 1: zero switches never write
    rst = 1'b0;
    wq.delete();
    tick(20);
    check("t1_writes", 32'(wq.size()), 0);
    check("t1_drop", 32'(drop_cnt), 0);

    // 2: latency of a single write
    sw_in = 8'h5A;
    tick(6);
    check("t2_e6_winc", 32'(winc), 0);
    check("t2_e6_pend", 32'(pending), 0);
    tick();
    check("t2_e7_winc", 32'(winc), 1);
    check("t2_e7_wdata", 32'(wdata), 32'h5A);
    check("t2_e7_pend", 32'(pending), 1);
    tick();
    check("t2_e8_winc", 32'(winc), 0);
    check("t2_e8_pend", 32'(pending), 0);
    check("t2_e8_nwr", 32'(wq.size()), 1);
    check("t2_e8_val", 32'(wq[0]), 32'h5A);
    tick(10);
    check("t2_single", 32'(wq.size()), 1);

    // 3: glitches filtered, then one clean write
    do_reset();
    for (int i = 0; i < 10; i++) begin
      sw_in = (i % 2 == 0) ? 8'h5A : 8'h00;
      tick(2);
    end
    sw_in = 8'h00;
    tick(10);
    check("t3_glitch", 32'(wq.size()), 0);
    sw_in = 8'h3C;
    tick(15);
    check("t3_nwr", 32'(wq.size()), 1);
    check("t3_val", 32'(wq[0]), 32'h3C);
    check("t3_pend", 32'(pending), 0);

    // 4: back-pressure, latest wins, drop counted
    do_reset();
    full = 1'b1;
    sw_in = 8'h11;
    tick(7);
    check("t4_p1", 32'(pending), 1);
    check("t4_w1", 32'(winc), 0);
    check("t4_d1", 32'(wdata), 32'h11);
    sw_in = 8'h22;
    tick(7);
    check("t4_p2", 32'(pending), 1);
    check("t4_w2", 32'(winc), 0);
    check("t4_d2", 32'(wdata), 32'h22);
    check("t4_drop", 32'(drop_cnt), 1);
    tick(5);
    check("t4_hold", 32'(wdata), 32'h22);
    check("t4_nwr0", 32'(wq.size()), 0);
    full = 1'b0;
    #1;
    check("t4_winc", 32'(winc), 1);
    tick();
    check("t4_nwr", 32'(wq.size()), 1);
    check("t4_val", 32'(wq[0]), 32'h22);
    check("t4_idle", 32'(pending), 0);
    check("t4_drop2", 32'(drop_cnt), 1);

    // 5: new value lands on the write edge
    do_reset();
    full = 1'b1;
    sw_in = 8'h66;
    tick(9);
    check("t5_d66", 32'(wdata), 32'h66);
    sw_in = 8'h77;
    tick(6);
    check("t5_w0", 32'(winc), 0);
    full = 1'b0;
    #1;
    check("t5_w1", 32'(winc), 1);
    check("t5_d1", 32'(wdata), 32'h66);
    tick();
    check("t5_nwr1", 32'(wq.size()), 1);
    check("t5_v1", 32'(wq[0]), 32'h66);
    check("t5_pend", 32'(pending), 1);
    check("t5_w2", 32'(winc), 1);
    check("t5_d2", 32'(wdata), 32'h77);
    tick();
    check("t5_nwr2", 32'(wq.size()), 2);
    check("t5_v2", 32'(wq[1]), 32'h77);
    check("t5_idle", 32'(pending), 0);
    check("t5_drop", 32'(drop_cnt), 0);

    // 6: async reset mid-PEND
    do_reset();
    full = 1'b1;
    sw_in = 8'h44;
    tick(7);
    sw_in = 8'h55;
    tick(7);
    check("t6_drop", 32'(drop_cnt), 1);
    full = 1'b0;
    #1;
    check("t6_winc", 32'(winc), 1);
    #2;
    rst = 1'b1;
    sw_in = 8'h00;
    #1;
    check("t6_r_winc", 32'(winc), 0);
    check("t6_r_pend", 32'(pending), 0);
    check("t6_r_wdata", 32'(wdata), 0);
    check("t6_r_drop", 32'(drop_cnt), 0);
    tick();
    check("t6_nowr", 32'(wq.size()), 0);
    rst = 1'b0;
    tick(12);
    check("t6_quiet", 32'(wq.size()), 0);
    sw_in = 8'h99;
    tick(15);
    check("t6_nwr", 32'(wq.size()), 1);
    check("t6_val", 32'(wq[0]), 32'h99);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
